video_timing: RTL and testbench
===============================

// Module: video_timing
// PURPOSE
//  Generates 640x480@60 VGA raster timing from the pixel clock. Derives 256x240
//  game-pixel coordinates (2x scaled, horizontally centred) that feed every GPU
//  layer (text, background, sprites); those layers then return per-pixel colour
//  and valid to the compositor.
//  Emits sync, blanking, vblank interrupt pulse and frame counter.
//  Sync and blank outputs are delayed LEAD cycles so they stay aligned with the
//  pipelined layer/compositor path.
// PARAMETERS
//  H_VISIBLE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (H_TOTAL=800)
//  V_VISIBLE 480 visible lines;  V_FP 10;  V_SYNC 2;  V_BP 33  (V_TOTAL=525)
//  H_OFFSET  64  first hcount of the 512-wide game window (256 game px x2)
//  LEAD      2   cycles by which coordinates lead sync/video_on (legal 0..7)
// PORTS
//  gpu_clk          in   1   pixel clock (25.175 MHz)
//  rst_n            in   1   asynchronous active-low reset
//  display_x_o      out  8   game-pixel column 0..255 (0 outside window)
//  display_y_o      out  8   game-pixel row 0..239 (0 during vblank)
//  display_active_o out  1   coords valid: inside 256x240 window
//  vblank_o         out  1   level: vcount >= V_VISIBLE (coordinate phase)
//  vblank_start_o   out  1   1-cycle pulse at hcount=0, vcount=V_VISIBLE (CPU NMI)
//  frame_count_o    out  8   frames completed, wraps 255->0
//  hsync_n_o        out  1   active-low hsync, delayed LEAD
//  vsync_n_o        out  1   active-low vsync, delayed LEAD
//  video_on_o       out  1   inside 640x480 visible region, delayed LEAD
// BEHAVIOUR
//  - Counters hcount[9:0], vcount[9:0] advance every gpu_clk edge. hcount wraps
//    H_TOTAL-1->0 and increments vcount; vcount wraps V_TOTAL-1->0 on the same
//    edge, which also increments frame_count (8-bit, modulo 256).
//  - All outputs are registered. They decode the counter value held in the
//    previous cycle (1-cycle latency). sync/video_on pass through an additional
//    LEAD-deep shift register (LEAD=0: no extra delay).
//  - active = (H_OFFSET <= hcount < H_OFFSET+512) && (vcount < V_VISIBLE).
//  - display_x = (hcount-H_OFFSET)>>1 truncated to 8 bits when active, else 0.
//  - display_y = vcount>>1 truncated to 8 bits when vcount < V_VISIBLE, else 0.
//  - hsync_n low for hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC).
//  - vsync_n low for whole lines vcount in [V_VISIBLE+V_FP, +V_SYNC).
//  - video_on = hcount<H_VISIBLE && vcount<V_VISIBLE.
//  - vblank_start asserts exactly once per frame, never on reset release.
//  - Reset (async, any time incl. mid-frame): hcount=vcount=0, frame_count=0;
//    display_x/y=0, display_active=0, vblank=0, vblank_start=0, video_on=0,
//    hsync_n=1, vsync_n=1. Delay-line stages reset to these same inactive values.
//  - First edge after release loads outputs for (0,0); the counter moves to (1,0).
//  - Elaboration error if LEAD>7 or H_OFFSET+512 > H_VISIBLE.
// TESTING
//  1 Assert rst_n=0 mid-frame at hcount=300, vcount=100 -> all outputs take reset
//    values without a clock edge; after release, display_y=0 and frame_count=0.
//  2 Default params -> hsync_n falls 656+1+LEAD cycles after line start and stays
//    low 96 cycles. Line period is 800 cycles; vsync_n is low for exactly 1600 cycles.
//  3 Line 0 -> display_active rises with display_x=0 at hcount 64 (+1 latency).
//    display_x=1 at hcount 66 and 255 at hcount 574..575; active=0 from hcount 576.
//  4 Frame run -> vblank_start high 1 cycle, 384000 cycles after frame start.
//    Spacing between pulses is 420000; vblank_o high for 36000 cycles.
//  5 Run 256 frames -> frame_count steps 254, 255, 0 on successive vcount wraps.
//  6 LEAD=0 vs LEAD=5 builds -> video_on/hsync_n edges shift by exactly 5 cycles.
//    display_x/y timing is identical between the two builds.

Source files
------------

// File: rtl/video_timing.sv
// rtl/video_timing.sv - VGA raster timing with 2x-scaled 256x240 game-pixel coordinates
module video_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_OFFSET  = 64,
    parameter int LEAD      = 2
) (
    input  logic       gpu_clk,
    input  logic       rst_n,
    output logic [7:0] display_x_o,
    output logic [7:0] display_y_o,
    output logic       display_active_o,
    output logic       vblank_o,
    output logic       vblank_start_o,
    output logic [7:0] frame_count_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       video_on_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_WIN_LO = 10'(H_OFFSET);
    localparam logic [9:0] H_WIN_HI = 10'(H_OFFSET + 512);
    localparam logic [9:0] HS_LO    = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI    = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO    = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI    = 10'(V_VISIBLE + V_FP + V_SYNC);

    // {hsync_n, vsync_n, video_on} when idle
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    if (LEAD > 7 || H_OFFSET + 512 > H_VISIBLE) begin : g_param_check
        $error("video_timing: LEAD must be 0..7 and the game window must fit in H_VISIBLE");
    end

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [7:0] frame_cnt;

    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            if (vcount == V_LAST) begin
                vcount    <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                vcount <= vcount + 10'd1;
            end
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    logic       active_c;
    logic       vvis_c;
    logic [7:0] dx_c;
    logic [7:0] dy_c;
    logic [2:0] sync_c;

    always_comb begin
        vvis_c   = (vcount < V_VIS);
        active_c = (hcount >= H_WIN_LO) && (hcount < H_WIN_HI) && vvis_c;
        dx_c     = active_c ? 8'((hcount - H_WIN_LO) >> 1) : 8'd0;
        dy_c     = vvis_c ? 8'(vcount >> 1) : 8'd0;
        sync_c   = {!((hcount >= HS_LO) && (hcount < HS_HI)),
                    !((vcount >= VS_LO) && (vcount < VS_HI)),
                    (hcount < H_VIS) && vvis_c};
    end

    logic [2:0] sync_q;

    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            display_x_o      <= '0;
            display_y_o      <= '0;
            display_active_o <= 1'b0;
            vblank_o         <= 1'b0;
            vblank_start_o   <= 1'b0;
            frame_count_o    <= '0;
            sync_q           <= SYNC_IDLE;
        end else begin
            display_x_o      <= dx_c;
            display_y_o      <= dy_c;
            display_active_o <= active_c;
            vblank_o         <= !vvis_c;
            vblank_start_o   <= (hcount == 10'd0) && (vcount == V_VIS);
            frame_count_o    <= frame_cnt;
            sync_q           <= sync_c;
        end
    end

    // Extra delay keeps sync/video_on aligned with the layer/compositor pipeline
    if (LEAD == 0) begin : g_no_lead
        assign {hsync_n_o, vsync_n_o, video_on_o} = sync_q;
    end else begin : g_lead
        logic [2:0] dly [LEAD];

        always_ff @(posedge gpu_clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LEAD; i++) dly[i] <= SYNC_IDLE;
            end else begin
                dly[0] <= sync_q;
                for (int i = 1; i < LEAD; i++) dly[i] <= dly[i-1];
            end
        end

        assign {hsync_n_o, vsync_n_o, video_on_o} = dly[LEAD-1];
    end

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - randomized-reset bench for video_timing against a cycle-index model
module tb_video_timing;

    localparam int HT  = 800;
    localparam int VV  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic [7:0] dx;
        logic [7:0] dy;
        logic       act;
        logic       vbl;
        logic       vbs;
        logic [7:0] fc;
        logic       hs;
        logic       vs;
        logic       von;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obs_t obs [3];

    function automatic int lead_of(int g);
        return (g == 0) ? 0 : ((g == 1) ? 2 : 5);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] dx, dy, fc;
        logic       act, vbl, vbs, hs, vs, von;

        video_timing #(
            .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
            .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
            .H_OFFSET(64), .LEAD((g == 0) ? 0 : ((g == 1) ? 2 : 5))
        ) u_dut (
            .gpu_clk         (clk),
            .rst_n           (rst_n),
            .display_x_o     (dx),
            .display_y_o     (dy),
            .display_active_o(act),
            .vblank_o        (vbl),
            .vblank_start_o  (vbs),
            .frame_count_o   (fc),
            .hsync_n_o       (hs),
            .vsync_n_o       (vs),
            .video_on_o      (von)
        );

        assign obs[g] = '{dx: dx, dy: dy, act: act, vbl: vbl, vbs: vbs,
                          fc: fc, hs: hs, vs: vs, von: von};
    end

    // Clock edges seen since the last reset release
    longint n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // After edge n the coordinate outputs describe raster position n-1,
    // and sync/video_on describe position n-1-lead (idle before that exists).
    function automatic obs_t model(longint cyc, int lead);
        obs_t   e;
        longint p, q;
        int     h, v, h2, v2;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (cyc < 1) return e;
        p     = cyc - 1;
        h     = int'(p % HT);
        v     = int'((p / HT) % VT);
        e.act = (h >= 64) && (h < 576) && (v < VV);
        e.dx  = e.act ? 8'((h - 64) / 2) : 8'd0;
        e.dy  = (v < VV) ? 8'(v / 2) : 8'd0;
        e.vbl = (v >= VV);
        e.vbs = (h == 0) && (v == VV);
        e.fc  = 8'((p / FT) % 256);
        q = cyc - 1 - lead;
        if (q >= 0) begin
            h2    = int'(q % HT);
            v2    = int'((q / HT) % VT);
            e.hs  = !((h2 >= 656) && (h2 < 752));
            e.vs  = !((v2 >= VV + VFP) && (v2 < VV + VFP + VS));
            e.von = (h2 < 640) && (v2 < VV);
        end
        return e;
    endfunction

    int tests  = 0;
    int fails  = 0;
    int shown  = 0;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (shown < 40) begin
                shown++;
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++)
            check($sformatf("model lead%0d n=%0d", lead_of(g), n),
                  longint'(obs[g]), longint'(model(n, lead_of(g))));
    end

    // Event capture during the first undisturbed frames
    logic   p1 = 1'b0;
    longint hs_fall [3];
    longint von_fall[3];
    logic   prev_hs [3];
    logic   prev_von[3];
    longint vbs_first = 0, vbs_second = 0;
    int     vbl_cnt = 0, vs_cnt = 0;
    logic [8:0] snap [6];

    initial begin
        for (int g = 0; g < 3; g++) begin
            hs_fall[g] = 0; von_fall[g] = 0; prev_hs[g] = 1'b1; prev_von[g] = 1'b0;
        end
        for (int i = 0; i < 6; i++) snap[i] = '0;
    end

    always @(negedge clk) begin
        if (p1 && rst_n) begin
            for (int g = 0; g < 3; g++) begin
                if (prev_hs[g] && !obs[g].hs && hs_fall[g] == 0) hs_fall[g] = n;
                if (prev_von[g] && !obs[g].von && von_fall[g] == 0) von_fall[g] = n;
                prev_hs[g]  = obs[g].hs;
                prev_von[g] = obs[g].von;
            end
            if (obs[1].vbs) begin
                if (vbs_first == 0) vbs_first = n;
                else if (vbs_second == 0) vbs_second = n;
            end
            if (n <= FT && obs[1].vbl) vbl_cnt++;
            if (n <= FT && !obs[1].vs) vs_cnt++;
            case (n)
                64:  snap[0] = {obs[1].act, obs[1].dx};
                65:  snap[1] = {obs[1].act, obs[1].dx};
                67:  snap[2] = {obs[1].act, obs[1].dx};
                575: snap[3] = {obs[1].act, obs[1].dx};
                576: snap[4] = {obs[1].act, obs[1].dx};
                577: snap[5] = {obs[1].act, obs[1].dx};
                6400: check("fc_before_wrap", longint'(obs[1].fc), 0);
                6401: check("fc_after_wrap", longint'(obs[1].fc), 1);
                default: ;
            endcase
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", longint'(obs[1]), 6);
        #2 rst_n = 1'b1;
        p1 = 1'b1;
        repeat (13000) @(negedge clk);
        p1 = 1'b0;

        check("hs_fall_lead0", hs_fall[0], 657);
        check("hs_fall_lead2", hs_fall[1], 659);
        check("hs_fall_lead5", hs_fall[2], 662);
        check("hs_shift_0_5", hs_fall[2] - hs_fall[0], 5);
        check("von_shift_0_5", von_fall[2] - von_fall[0], 5);
        check("von_fall_lead0", von_fall[0], 641);
        check("vbs_first", vbs_first, 3201);
        check("vbs_spacing", vbs_second - vbs_first, FT);
        check("vblank_len", vbl_cnt, 3200);
        check("vsync_len", vs_cnt, 1600);
        check("win_before", snap[0], 9'h000);
        check("win_rise", snap[1], 9'h100);
        check("win_x1", snap[2], 9'h101);
        check("win_x255a", snap[3], 9'h1ff);
        check("win_x255b", snap[4], 9'h1ff);
        check("win_after", snap[5], 9'h000);

        // Asynchronous reset mid-line at hcount 300
        do begin
            @(posedge clk);
            #1;
        end while (n % HT != 300);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++)
            check($sformatf("async_reset lead%0d", lead_of(g)), longint'(obs[g]), 6);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_dy", longint'(obs[1].dy), 0);
        check("post_reset_fc", longint'(obs[1].fc), 0);
        check("post_reset_vbs", longint'(obs[1].vbs), 0);

        // Random run lengths and reset instants
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(100, 12000)) @(posedge clk);
            #($urandom_range(1, 4)) rst_n = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (2000) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
